// File: rtl/logic_gates.sv
// Bitwise two-input gate bank with zero-latency outputs and a one-cycle
// registered snapshot of all eight results plus a sample-valid flag.
module logic_gates #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     and_g,
  output logic [WIDTH-1:0]     or_g,
  output logic [WIDTH-1:0]     not_g,
  output logic [WIDTH-1:0]     buf_g,
  output logic [WIDTH-1:0]     nand_g,
  output logic [WIDTH-1:0]     nor_g,
  output logic [WIDTH-1:0]     xor_g,
  output logic [WIDTH-1:0]     xnor_g,
  output logic [8*WIDTH-1:0]   gates_q,
  output logic                 q_valid
);

  localparam int unsigned NUM_GATES = 8;
  localparam int unsigned GATES_W   = NUM_GATES * WIDTH;

  logic [GATES_W-1:0] gates_d;
  logic               q_valid_d;
  logic               q_valid_q;

  // Gate bank; each lane uses only its own a/b bits.
  always_comb begin
    and_g  = a & b;
    or_g   = a | b;
    not_g  = ~a;
    buf_g  = a;
    nand_g = ~(a & b);
    nor_g  = ~(a | b);
    xor_g  = a ^ b;
    xnor_g = ~(a ^ b);
  end

  // Snapshot packing: slice k at [k*WIDTH +: WIDTH], and in slice 0 up to xnor in slice 7.
  always_comb begin
    gates_d   = {xnor_g, xor_g, nor_g, nand_g, buf_g, not_g, or_g, and_g};
    q_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gates_q   <= '0;
      q_valid_q <= 1'b0;
    end else begin
      gates_q   <= gates_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates: truth tables at WIDTH=1 and WIDTH=4, and
// reset/latency behaviour of the registered snapshot.
module tb_logic_gates;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;

  logic [0:0] and1, or1, not1, buf1, nand1, nor1, xor1, xnor1;
  logic [7:0] gq1;
  logic       qv1;
  logic [3:0] and4, or4, not4, buf4, nand4, nor4, xor4, xnor4;
  logic [31:0] gq4;
  logic       qv4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  logic_gates #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .and_g(and1), .or_g(or1), .not_g(not1), .buf_g(buf1),
    .nand_g(nand1), .nor_g(nor1), .xor_g(xor1), .xnor_g(xnor1),
    .gates_q(gq1), .q_valid(qv1)
  );

  logic_gates #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .and_g(and4), .or_g(or4), .not_g(not4), .buf_g(buf4),
    .nand_g(nand4), .nor_g(nor4), .xor_g(xor4), .xnor_g(xnor4),
    .gates_q(gq4), .q_valid(qv4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] comb1();
    return {xnor1, xor1, nor1, nand1, buf1, not1, or1, and1};
  endfunction

  function automatic logic [31:0] comb4();
    return {xnor4, xor4, nor4, nand4, buf4, not4, or4, and4};
  endfunction

  initial begin
    logic [3:0] ea, eb, e_and, e_or, e_xor;
    logic [31:0] e4;

    // Combinational truth table, no clock edge needed
    a1 = 1'b0; b1 = 1'b0; #1;
    check("comb_a0b0", 32'(comb1()), 32'h0000_00B4);
    a1 = 1'b0; b1 = 1'b1; #1;
    check("comb_a0b1", 32'(comb1()), 32'h0000_0056);
    a1 = 1'b1; b1 = 1'b0; #1;
    check("comb_a1b0", 32'(comb1()), 32'h0000_005A);
    a1 = 1'b1; b1 = 1'b1; #1;
    check("comb_a1b1", 32'(comb1()), 32'h0000_008B);

    // Toggling b alone leaves not/buf untouched
    b1 = 1'b0; #1;
    check("notbuf_b0", 32'({not1, buf1}), 32'h1);
    b1 = 1'b1; #1;
    check("notbuf_b1", 32'({not1, buf1}), 32'h1);
    a1 = 1'b0; b1 = 1'b0; #1;
    b1 = 1'b1; #1;
    check("notbuf_a0", 32'({not1, buf1}), 32'h2);

    // Reset held for two edges with a=b=1
    a1 = 1'b1; b1 = 1'b1; rst = 1'b1;
    tick();
    check("rst_edge1_q", 32'(gq1), 32'h0);
    check("rst_edge1_v", 32'(qv1), 32'h0);
    tick();
    check("rst_edge2_q", 32'(gq1), 32'h0);
    check("rst_edge2_v", 32'(qv1), 32'h0);
    rst = 1'b0;
    tick();
    check("rel_q", 32'(gq1), 32'h8B);
    check("rel_v", 32'(qv1), 32'h1);

    // One-cycle latency: new inputs show only after the next edge
    a1 = 1'b0; b1 = 1'b1; #2;
    check("lat_hold", 32'(gq1), 32'h8B);
    tick();
    check("lat_upd1", 32'(gq1), 32'h56);
    a1 = 1'b1; b1 = 1'b0;
    tick();
    check("lat_upd2", 32'(gq1), 32'h5A);

    // Reset mid-stream, then release
    a1 = 1'b0; b1 = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_q", 32'(gq1), 32'h0);
    check("mid_rst_v", 32'(qv1), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_q", 32'(gq1), 32'hB4);
    check("post_rst_v", 32'(qv1), 32'h1);

    // WIDTH=4 directed vector
    a4 = 4'b1100; b4 = 4'b1010; #1;
    check("w4_and",  32'(and4),  32'h8);
    check("w4_or",   32'(or4),   32'hE);
    check("w4_not",  32'(not4),  32'h3);
    check("w4_buf",  32'(buf4),  32'hC);
    check("w4_nand", 32'(nand4), 32'h7);
    check("w4_nor",  32'(nor4),  32'h1);
    check("w4_xor",  32'(xor4),  32'h6);
    check("w4_xnor", 32'(xnor4), 32'h9);
    tick();
    check("w4_snap", gq4, 32'h9617_C3E8);
    check("w4_valid", 32'(qv4), 32'h1);

    // All 256 operand pairs against a per-lane model
    for (int i = 0; i < 256; i++) begin
      {a4, b4} = 8'(i);
      #1;
      ea = 4'(i >> 4);
      eb = 4'(i);
      e_and = '0; e_or = '0; e_xor = '0;
      for (int k = 0; k < 4; k++) begin
        e_and[k] = ea[k] && eb[k];
        e_or[k]  = ea[k] || eb[k];
        e_xor[k] = ea[k] != eb[k];
      end
      e4 = {~e_xor, e_xor, ~e_or, ~e_and, ea, ~ea, e_or, e_and};
      check($sformatf("w4_sweep_%0d", i), comb4(), e4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
